load_buffer_tracker: RTL and testbench

// - Tracks outstanding loads between the load unit and the dcache request port.
// - Sized from cva6_cfg.NrLoadBufEntries; XLEN comes from the same config.
// - Allocates one slot per issued load; the slot index is the dcache request ID.
// - Holds trans_id, byte offset, size and sign for each slot.
// - Matches dcache responses by ID, then aligns and extends the data.
// - Drives one registered writeback toward the scoreboard.

---
 rtl/load_buffer_tracker.sv | 203 ++++++++++++++++++++
 tb/tb_load_buffer_tracker.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_buffer_tracker.sv
// Outstanding-load tracker between the load unit and the dcache: slot allocation,
// response matching, data alignment/extension and a registered writeback.
// Optional LOAD_BUF_ERR_CHECK_EN adds a sticky spurious_rsp_o flag.
module load_buffer_tracker #(
    parameter int unsigned NR_ENTRIES    = 2,
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = 3,
    localparam int unsigned ID_BITS      = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1,
    localparam int unsigned OFF_BITS     = $clog2(XLEN / 8)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     alloc_valid_i,
    output logic                     alloc_ready_o,
    output logic [ID_BITS-1:0]       alloc_id_o,
    input  logic [TRANS_ID_BITS-1:0] alloc_trans_id_i,
    input  logic [OFF_BITS-1:0]      alloc_offset_i,
    input  logic [1:0]               alloc_size_i,
    input  logic                     alloc_sign_i,
    input  logic                     kill_valid_i,
    input  logic [ID_BITS-1:0]       kill_id_i,
    input  logic                     rsp_valid_i,
    input  logic [ID_BITS-1:0]       rsp_id_i,
    input  logic [XLEN-1:0]          rsp_data_i,
    output logic                     wb_valid_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [XLEN-1:0]          wb_data_o,
    output logic                     empty_o
`ifdef LOAD_BUF_ERR_CHECK_EN
    ,
    output logic                     spurious_rsp_o
`endif
);

    logic [NR_ENTRIES-1:0]    valid_q, valid_d;
    logic [NR_ENTRIES-1:0]    flushed_q, flushed_d;
    logic [NR_ENTRIES-1:0]    sign_q, sign_d;
    logic [TRANS_ID_BITS-1:0] trans_q [NR_ENTRIES];
    logic [TRANS_ID_BITS-1:0] trans_d [NR_ENTRIES];
    logic [OFF_BITS-1:0]      off_q [NR_ENTRIES];
    logic [OFF_BITS-1:0]      off_d [NR_ENTRIES];
    logic [1:0]               size_q [NR_ENTRIES];
    logic [1:0]               size_d [NR_ENTRIES];

    logic                     wb_valid_q, wb_valid_d;
    logic [TRANS_ID_BITS-1:0] wb_trans_q, wb_trans_d;
    logic [XLEN-1:0]          wb_data_q, wb_data_d;

    logic                     found;
    logic                     rsp_hit, kill_hit, rsp_flushed, rsp_sign, wb_fire, msb;
    logic [TRANS_ID_BITS-1:0] rsp_trans;
    logic [OFF_BITS-1:0]      rsp_off;
    logic [1:0]               rsp_size;
    logic [XLEN-1:0]          shifted, mask, ext_data;

    // Lowest free slot; 0 when the buffer is full.
    always_comb begin
        alloc_ready_o = |(~valid_q);
        alloc_id_o    = '0;
        found         = 1'b0;
        for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            if (!valid_q[i] && !found) begin
                alloc_id_o = ID_BITS'(i);
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        valid_d     = valid_q;
        flushed_d   = flushed_q;
        sign_d      = sign_q;
        trans_d     = trans_q;
        off_d       = off_q;
        size_d      = size_q;
        rsp_hit     = 1'b0;
        kill_hit    = 1'b0;
        rsp_flushed = 1'b0;
        rsp_sign    = 1'b0;
        rsp_trans   = '0;
        rsp_off     = '0;
        rsp_size    = '0;

        if (flush_i) begin
            flushed_d = flushed_q | valid_q;
        end

        for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            if (rsp_valid_i && rsp_id_i == ID_BITS'(i) && valid_q[i]) begin
                rsp_hit     = 1'b1;
                rsp_flushed = flushed_q[i];
                rsp_sign    = sign_q[i];
                rsp_trans   = trans_q[i];
                rsp_off     = off_q[i];
                rsp_size    = size_q[i];
                valid_d[i]  = 1'b0;
            end
            if (kill_valid_i && kill_id_i == ID_BITS'(i) && valid_q[i]) begin
                kill_hit   = 1'b1;
                valid_d[i] = 1'b0;
            end
        end

        // Allocation only ever targets a slot that was free before the edge,
        // so it cannot collide with a slot being released this cycle.
        if (alloc_valid_i && alloc_ready_o) begin
            for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                if (alloc_id_o == ID_BITS'(i)) begin
                    valid_d[i]   = 1'b1;
                    flushed_d[i] = 1'b0;
                    sign_d[i]    = alloc_sign_i;
                    trans_d[i]   = alloc_trans_id_i;
                    off_d[i]     = alloc_offset_i;
                    size_d[i]    = alloc_size_i;
                end
            end
        end
    end

    always_comb begin
        shifted = rsp_data_i >> {rsp_off, 3'b000};
        case (rsp_size)
            2'b00: begin
                mask = XLEN'(8'hFF);
                msb  = shifted[7];
            end
            2'b01: begin
                mask = XLEN'(16'hFFFF);
                msb  = shifted[15];
            end
            2'b10: begin
                mask = XLEN'(32'hFFFF_FFFF);
                msb  = shifted[31];
            end
            default: begin
                mask = '1;
                msb  = shifted[XLEN-1];
            end
        endcase
        ext_data = (rsp_sign && msb) ? (shifted | ~mask) : (shifted & mask);

        wb_fire    = rsp_hit && !rsp_flushed && !flush_i &&
                     !(kill_hit && kill_id_i == rsp_id_i);
        wb_valid_d = wb_fire;
        wb_trans_d = wb_fire ? rsp_trans : wb_trans_q;
        wb_data_d  = wb_fire ? ext_data : wb_data_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q    <= '0;
            flushed_q  <= '0;
            sign_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_trans_q <= '0;
            wb_data_q  <= '0;
            for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                trans_q[i] <= '0;
                off_q[i]   <= '0;
                size_q[i]  <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            flushed_q  <= flushed_d;
            sign_q     <= sign_d;
            trans_q    <= trans_d;
            off_q      <= off_d;
            size_q     <= size_d;
            wb_valid_q <= wb_valid_d;
            wb_trans_q <= wb_trans_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign wb_valid_o    = wb_valid_q;
    assign wb_trans_id_o = wb_trans_q;
    assign wb_data_o     = wb_data_q;
    assign empty_o       = ~|valid_q;

`ifdef LOAD_BUF_ERR_CHECK_EN
    logic spur_q, spur_d;
    logic rsp_slot_busy, kill_slot_busy;

    always_comb begin
        rsp_slot_busy  = 1'b0;
        kill_slot_busy = 1'b0;
        for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            if (rsp_id_i == ID_BITS'(i) && valid_q[i]) rsp_slot_busy = 1'b1;
            if (kill_id_i == ID_BITS'(i) && valid_q[i]) kill_slot_busy = 1'b1;
        end
        spur_d = spur_q | (rsp_valid_i && !rsp_slot_busy) | (kill_valid_i && !kill_slot_busy);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) spur_q <= 1'b0;
        else         spur_q <= spur_d;
    end

    assign spurious_rsp_o = spur_q;
`endif

endmodule

// File: tb/tb_load_buffer_tracker.sv
// Directed bench for load_buffer_tracker (NR_ENTRIES=2, XLEN=64, TRANS_ID_BITS=3).
module tb_load_buffer_tracker;

    localparam int unsigned NR  = 2;
    localparam int unsigned XL  = 64;
    localparam int unsigned TIB = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush, alloc_valid, alloc_ready, alloc_sign;
    logic [0:0]    alloc_id, kill_id, rsp_id;
    logic [2:0]    alloc_trans, alloc_off, wb_trans;
    logic [1:0]    alloc_size;
    logic          kill_valid, rsp_valid, wb_valid, empty;
    logic [63:0]   rsp_data, wb_data;
`ifdef LOAD_BUF_ERR_CHECK_EN
    logic          spurious;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_buffer_tracker #(
        .NR_ENTRIES    (NR),
        .XLEN          (XL),
        .TRANS_ID_BITS (TIB)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .flush_i          (flush),
        .alloc_valid_i    (alloc_valid),
        .alloc_ready_o    (alloc_ready),
        .alloc_id_o       (alloc_id),
        .alloc_trans_id_i (alloc_trans),
        .alloc_offset_i   (alloc_off),
        .alloc_size_i     (alloc_size),
        .alloc_sign_i     (alloc_sign),
        .kill_valid_i     (kill_valid),
        .kill_id_i        (kill_id),
        .rsp_valid_i      (rsp_valid),
        .rsp_id_i         (rsp_id),
        .rsp_data_i       (rsp_data),
        .wb_valid_o       (wb_valid),
        .wb_trans_id_o    (wb_trans),
        .wb_data_o        (wb_data),
        .empty_o          (empty)
`ifdef LOAD_BUF_ERR_CHECK_EN
        ,
        .spurious_rsp_o   (spurious)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        flush       = 1'b0;
        alloc_valid = 1'b0;
        kill_valid  = 1'b0;
        rsp_valid   = 1'b0;
    endtask

    task automatic alloc(input logic [2:0] t, input logic [2:0] off, input logic [1:0] sz,
                         input logic sg);
        alloc_valid = 1'b1;
        alloc_trans = t;
        alloc_off   = off;
        alloc_size  = sz;
        alloc_sign  = sg;
    endtask

    task automatic rsp(input logic [0:0] id, input logic [63:0] d);
        rsp_valid = 1'b1;
        rsp_id    = id;
        rsp_data  = d;
    endtask

    // One complete load: allocate into slot 0, respond, check the writeback.
    task automatic one_load(input string tag, input logic [2:0] t, input logic [2:0] off,
                            input logic [1:0] sz, input logic sg, input logic [63:0] d,
                            input logic [63:0] exp);
        alloc(t, off, sz, sg);
        step();
        idle();
        rsp(1'b0, d);
        step();
        idle();
        check({tag, "_wbv"}, 64'(wb_valid), 64'd1);
        check({tag, "_trans"}, 64'(wb_trans), 64'(t));
        check({tag, "_data"}, wb_data, exp);
    endtask

    initial begin
        rst_n       = 1'b0;
        idle();
        alloc_trans = '0;
        alloc_off   = '0;
        alloc_size  = '0;
        alloc_sign  = 1'b0;
        kill_id     = '0;
        rsp_id      = '0;
        rsp_data    = '0;
        step();
        step();
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_ready", 64'(alloc_ready), 64'd1);
        check("rst_wbv", 64'(wb_valid), 64'd0);
        check("rst_trans", 64'(wb_trans), 64'd0);
        check("rst_data", wb_data, 64'd0);
        check("rst_id", 64'(alloc_id), 64'd0);
`ifdef LOAD_BUF_ERR_CHECK_EN
        check("rst_spur", 64'(spurious), 64'd0);
`endif
        rst_n = 1'b1;
        step();

        // Doubleword load, one-cycle latency, then hold
        alloc(3'd5, 3'd0, 2'b11, 1'b0);
        check("d_id", 64'(alloc_id), 64'd0);
        step();
        idle();
        check("d_busy", 64'(empty), 64'd0);
        check("d_next_id", 64'(alloc_id), 64'd1);
        rsp(1'b0, 64'h1122334455667788);
        check("d_no_early_wb", 64'(wb_valid), 64'd0);
        step();
        idle();
        check("d_wbv", 64'(wb_valid), 64'd1);
        check("d_trans", 64'(wb_trans), 64'd5);
        check("d_data", wb_data, 64'h1122334455667788);
        check("d_empty", 64'(empty), 64'd1);
        step();
        check("d_pulse", 64'(wb_valid), 64'd0);
        check("d_hold", wb_data, 64'h1122334455667788);

        one_load("b_s", 3'd2, 3'd7, 2'b00, 1'b1, 64'h80AB_CDEF_0123_4567, 64'hFFFF_FFFF_FFFF_FF80);
        one_load("b_u", 3'd3, 3'd7, 2'b00, 1'b0, 64'h80AB_CDEF_0123_4567, 64'h0000_0000_0000_0080);
        one_load("h_s", 3'd4, 3'd2, 2'b01, 1'b1, 64'h1234_5678_8001_ABCD, 64'hFFFF_FFFF_FFFF_8001);
        one_load("w_s", 3'd6, 3'd4, 2'b10, 1'b1, 64'h7FFF_FFFF_0000_0000, 64'h0000_0000_7FFF_FFFF);
        one_load("w_u", 3'd1, 3'd0, 2'b10, 1'b0, 64'h0000_0000_8000_0001, 64'h0000_0000_8000_0001);
        step();

        // Full buffer: third request is held until a slot frees
        alloc(3'd1, 3'd0, 2'b11, 1'b0);
        step();
        alloc(3'd2, 3'd0, 2'b11, 1'b0);
        check("full_id1", 64'(alloc_id), 64'd1);
        step();
        check("full_ready", 64'(alloc_ready), 64'd0);
        alloc(3'd7, 3'd0, 2'b11, 1'b0);
        step();
        check("full_held", 64'(alloc_ready), 64'd0);
        rsp(1'b1, 64'hAAAA);
        step();
        rsp_valid = 1'b0;
        check("full_wb1", 64'(wb_trans), 64'd2);
        check("full_ready_back", 64'(alloc_ready), 64'd1);
        check("full_free_id", 64'(alloc_id), 64'd1);
        step();
        alloc_valid = 1'b0;
        check("full_refill", 64'(alloc_ready), 64'd0);
        rsp(1'b0, 64'h11);
        step();
        check("full_wb0", 64'(wb_trans), 64'd1);
        rsp(1'b1, 64'h22);
        step();
        idle();
        check("full_wb_held", 64'(wb_trans), 64'd7);
        check("full_wb_held_d", wb_data, 64'h22);
        check("full_empty", 64'(empty), 64'd1);

        // Flush with a same-cycle allocation
        alloc(3'd1, 3'd0, 2'b11, 1'b0);
        step();
        alloc(3'd3, 3'd0, 2'b11, 1'b0);
        flush = 1'b1;
        step();
        idle();
        rsp(1'b0, 64'h33);
        step();
        idle();
        check("fl_no_wb", 64'(wb_valid), 64'd0);
        check("fl_busy", 64'(empty), 64'd0);
        check("fl_reuse_id", 64'(alloc_id), 64'd0);
        alloc(3'd4, 3'd0, 2'b11, 1'b0);
        step();
        idle();
        rsp(1'b0, 64'h44);
        step();
        idle();
        check("fl_new_wbv", 64'(wb_valid), 64'd1);
        check("fl_new_trans", 64'(wb_trans), 64'd4);
        rsp(1'b1, 64'h55);
        step();
        idle();
        check("fl_alloc_wbv", 64'(wb_valid), 64'd1);
        check("fl_alloc_trans", 64'(wb_trans), 64'd3);
        check("fl_empty", 64'(empty), 64'd1);

        // Response together with flush on the same slot
        alloc(3'd6, 3'd0, 2'b11, 1'b0);
        step();
        idle();
        rsp(1'b0, 64'h66);
        flush = 1'b1;
        step();
        idle();
        check("rf_no_wb", 64'(wb_valid), 64'd0);
        check("rf_empty", 64'(empty), 64'd1);

        // Kill alone, then kill racing a response
        alloc(3'd2, 3'd0, 2'b11, 1'b0);
        step();
        idle();
        kill_valid = 1'b1;
        kill_id    = 1'b0;
        step();
        idle();
        check("k_empty", 64'(empty), 64'd1);
        check("k_no_wb", 64'(wb_valid), 64'd0);
        alloc(3'd5, 3'd0, 2'b11, 1'b0);
        step();
        idle();
        kill_valid = 1'b1;
        kill_id    = 1'b0;
        rsp(1'b0, 64'h77);
        step();
        idle();
        check("kr_no_wb", 64'(wb_valid), 64'd0);
        check("kr_empty", 64'(empty), 64'd1);
`ifdef LOAD_BUF_ERR_CHECK_EN
        check("kr_spur_clear", 64'(spurious), 64'd0);
`endif
        rsp(1'b0, 64'h88);
        step();
        idle();
        check("free_rsp_no_wb", 64'(wb_valid), 64'd0);
        check("free_rsp_empty", 64'(empty), 64'd1);
`ifdef LOAD_BUF_ERR_CHECK_EN
        check("spur_set", 64'(spurious), 64'd1);
        step();
        check("spur_sticky", 64'(spurious), 64'd1);
`endif

        // Asynchronous reset with two slots busy
        alloc(3'd1, 3'd0, 2'b11, 1'b0);
        step();
        alloc(3'd2, 3'd0, 2'b11, 1'b0);
        step();
        idle();
        check("ar_full", 64'(alloc_ready), 64'd0);
        #1 rst_n = 1'b0;
        #1;
        check("ar_empty_now", 64'(empty), 64'd1);
        check("ar_wb_data", wb_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp(1'b0, 64'h99);
        step();
        idle();
        check("ar_no_wb", 64'(wb_valid), 64'd0);
        check("ar_empty", 64'(empty), 64'd1);
        check("ar_ready", 64'(alloc_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
